// File: rtl/isa_cycle_sequencer.sv
// isa_cycle_sequencer
// Sequences a single ISA I/O read or write cycle for the bus-interface datapath.
// A request is accepted in IDLE. The sequencer then runs address setup, the
// strobe-low period with IOCHRDY wait-state extension (bounded by TIMEOUT),
// capture, hold, and a one-cycle completion response.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   req_valid/ready   HPS request handshake; req_write selects write (1) or read (0)
//   iochrdy           raw ISA channel ready (asynchronous), low = insert wait states
//   address_load      latch HPS address into the bus-interface address register
//   data_load         latch data register (HPS data on writes, bus data on reads)
//   IOW, IOR          active-low ISA I/O strobes
//   busy              high from acceptance until the response pulse ends
//   rsp_valid         one-cycle completion pulse
//   rsp_timeout       wait-state limit expired, qualified by rsp_valid
module isa_cycle_sequencer #(
    parameter int unsigned ADDR_SETUP   = 2,
    parameter int unsigned STROBE_WIDTH = 8,
    parameter int unsigned HOLD         = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_write,
    output logic req_ready,
    input  logic iochrdy,
    output logic address_load,
    output logic data_load,
    output logic IOW,
    output logic IOR,
    output logic busy,
    output logic rsp_valid,
    output logic rsp_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StCapture,
        StHold,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;       // cycles remaining in the current phase, minus one
    logic [7:0] wait_q, wait_d;     // wait-state cycles already spent in WAIT
    logic       write_q, write_d;
    logic       timeout_q, timeout_d;
    logic       rdy_meta_q, rdy_sync_q;

    logic address_load_d, data_load_d, iow_d, ior_d;
    logic busy_d, req_ready_d, rsp_valid_d, rsp_timeout_d;
    logic strobe_low;

    // Two-flop synchronizer; resets to "ready" so no spurious wait states follow reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta_q <= 1'b1;
            rdy_sync_q <= 1'b1;
        end else begin
            rdy_meta_q <= iochrdy;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        write_d   = write_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d   = StSetup;
                    cnt_d     = 8'(ADDR_SETUP - 1);
                    write_d   = req_write;
                    timeout_d = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    state_d = StStrobe;
                    cnt_d   = 8'(STROBE_WIDTH - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 8'd0) begin
                    wait_d  = 8'd0;
                    state_d = rdy_sync_q ? StCapture : StWait;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StWait: begin
                wait_d = wait_q + 8'd1;
                // Ready takes priority over an expiry in the same cycle.
                if (rdy_sync_q) begin
                    state_d = StCapture;
                end else if (wait_q + 8'd1 == 8'(TIMEOUT)) begin
                    state_d   = StCapture;
                    timeout_d = 1'b1;
                end
            end
            StCapture: begin
                state_d = StHold;
                cnt_d   = 8'(HOLD - 1);
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        strobe_low     = state_d inside {StStrobe, StWait, StCapture};
        address_load_d = (state_q == StIdle) && (state_d == StSetup);
        data_load_d    = (address_load_d && write_d) || ((state_d == StCapture) && !write_d);
        iow_d          = !(strobe_low && write_d);
        ior_d          = !(strobe_low && !write_d);
        busy_d         = (state_d != StIdle);
        req_ready_d    = (state_d == StIdle);
        rsp_valid_d    = (state_d == StDone);
        rsp_timeout_d  = (state_d == StDone) && timeout_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            wait_q       <= 8'd0;
            write_q      <= 1'b0;
            timeout_q    <= 1'b0;
            address_load <= 1'b0;
            data_load    <= 1'b0;
            IOW          <= 1'b1;
            IOR          <= 1'b1;
            busy         <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            write_q      <= write_d;
            timeout_q    <= timeout_d;
            address_load <= address_load_d;
            data_load    <= data_load_d;
            IOW          <= iow_d;
            IOR          <= ior_d;
            busy         <= busy_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_timeout  <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Testbench for isa_cycle_sequencer: a default-parameter instance (a) and a
// TIMEOUT=4 instance (b). Cycle c of a transaction is the interval between
// edges E0+c-1 and E0+c, where E0 is the acceptance edge; outputs are sampled
// on the falling edge in the middle of each cycle.
module tb_isa_cycle_sequencer;

    localparam logic [15:0] BUS_VAL = 16'hA55A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req_write;
    logic req_valid_a, req_valid_b, iochrdy_a, iochrdy_b;
    logic req_ready_a, address_load_a, data_load_a, IOW_a, IOR_a, busy_a, rsp_valid_a, rsp_timeout_a;
    logic req_ready_b, address_load_b, data_load_b, IOW_b, IOR_b, busy_b, rsp_valid_b, rsp_timeout_b;
    logic sel;

    isa_cycle_sequencer dut_a (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid_a),
        .req_write    (req_write),
        .req_ready    (req_ready_a),
        .iochrdy      (iochrdy_a),
        .address_load (address_load_a),
        .data_load    (data_load_a),
        .IOW          (IOW_a),
        .IOR          (IOR_a),
        .busy         (busy_a),
        .rsp_valid    (rsp_valid_a),
        .rsp_timeout  (rsp_timeout_a)
    );

    isa_cycle_sequencer #(.TIMEOUT(4)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid_b),
        .req_write    (req_write),
        .req_ready    (req_ready_b),
        .iochrdy      (iochrdy_b),
        .address_load (address_load_b),
        .data_load    (data_load_b),
        .IOW          (IOW_b),
        .IOR          (IOR_b),
        .busy         (busy_b),
        .rsp_valid    (rsp_valid_b),
        .rsp_timeout  (rsp_timeout_b)
    );

    wire m_req_ready    = sel ? req_ready_b    : req_ready_a;
    wire m_address_load = sel ? address_load_b : address_load_a;
    wire m_data_load    = sel ? data_load_b    : data_load_a;
    wire m_IOW          = sel ? IOW_b          : IOW_a;
    wire m_IOR          = sel ? IOR_b          : IOR_a;
    wire m_busy         = sel ? busy_b         : busy_a;
    wire m_rsp_valid    = sel ? rsp_valid_b    : rsp_valid_a;
    wire m_rsp_timeout  = sel ? rsp_timeout_b  : rsp_timeout_a;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_valid(input logic v);
        if (sel) req_valid_b = v;
        else     req_valid_a = v;
    endtask

    task automatic set_rdy(input logic v);
        if (sel) iochrdy_b = v;
        else     iochrdy_a = v;
    endtask

    // low_from/low_to: raw iochrdy driven low/high just after edge E0+n (-1 = never).
    typedef struct {
        logic sel;
        logic wr;
        int   low_from;
        int   low_to;
        int   exp_low;   // strobe-low cycles of the active strobe
        int   exp_dl;    // cycle in which data_load is high
        int   exp_rsp;   // cycle in which rsp_valid is high
        logic exp_to;
    } vec_t;

    task automatic run_txn(input vec_t v, input string p);
        int addr_n = 0, addr_c = -1, dl_n = 0, dl_c = -1;
        int low_n = 0, first_low = -1, other_n = 0, both_n = 0;
        int rsp_c = -1, to_bad = 0;
        logic rsp_to = 1'b0, busy1 = 1'b0, rdy1 = 1'b1;
        logic [15:0] data_reg = 16'h0000;
        logic act_low, oth_low;
        sel = v.sel;
        @(negedge clk);
        check({p, " ready_before"}, int'(m_req_ready), 1);
        set_valid(1'b1);
        req_write = v.wr;
        @(posedge clk);
        #1;
        set_valid(1'b0);
        req_write = ~v.wr;
        if (v.low_from == 0) set_rdy(1'b0);
        for (int c = 1; c <= 80 && rsp_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy1 = m_busy;
                rdy1  = m_req_ready;
            end
            act_low = v.wr ? !m_IOW : !m_IOR;
            oth_low = v.wr ? !m_IOR : !m_IOW;
            if (m_address_load) begin
                addr_n++;
                if (addr_c < 0) addr_c = c;
            end
            if (m_data_load) begin
                dl_n++;
                if (dl_c < 0) dl_c = c;
            end
            // Datapath data register captures the bus only while IOR is low.
            if (m_data_load && !m_IOR) data_reg = BUS_VAL;
            if (act_low) begin
                low_n++;
                if (first_low < 0) first_low = c;
            end
            if (oth_low) other_n++;
            if (!m_IOW && !m_IOR) both_n++;
            if (m_rsp_valid) begin
                rsp_c  = c;
                rsp_to = m_rsp_timeout;
            end else if (m_rsp_timeout) begin
                to_bad++;
            end
            if (rsp_c < 0) begin
                @(posedge clk);
                #1;
                if (c == v.low_from) set_rdy(1'b0);
                if (c == v.low_to)   set_rdy(1'b1);
            end
        end
        check({p, " busy_c1"}, int'(busy1), 1);
        check({p, " ready_c1"}, int'(rdy1), 0);
        check({p, " addr_pulses"}, addr_n, 1);
        check({p, " addr_cycle"}, addr_c, 1);
        check({p, " dload_pulses"}, dl_n, 1);
        check({p, " dload_cycle"}, dl_c, v.exp_dl);
        check({p, " strobe_low"}, low_n, v.exp_low);
        check({p, " strobe_fall"}, first_low, 3);
        check({p, " other_strobe"}, other_n, 0);
        check({p, " both_low"}, both_n, 0);
        check({p, " rsp_cycle"}, rsp_c, v.exp_rsp);
        check({p, " rsp_timeout"}, int'(rsp_to), int'(v.exp_to));
        check({p, " timeout_unqual"}, to_bad, 0);
        if (!v.wr) check({p, " read_data"}, int'(data_reg), int'(BUS_VAL));
        @(negedge clk);
        check({p, " rsp_single"}, int'(m_rsp_valid), 0);
        check({p, " ready_after"}, int'(m_req_ready), 1);
        set_rdy(1'b1);
    endtask

    vec_t vecs[8];

    initial begin
        int n_rsp, first_rsp, second_acc, iow_n, ior_n, both_n;
        vec_t wv;

        vecs[0] = '{1'b0, 1'b1, -1, -1,  9,  1, 14, 1'b0};  // write, no wait
        vecs[1] = '{1'b0, 1'b0, -1, -1,  9, 11, 14, 1'b0};  // read, no wait
        vecs[2] = '{1'b0, 1'b0,  3, 20, 22, 24, 27, 1'b0};  // read, 13 wait states
        vecs[3] = '{1'b0, 1'b1,  5, 12, 14,  1, 19, 1'b0};  // write, 5 wait states
        vecs[4] = '{1'b0, 1'b0,  7,  9, 11, 13, 16, 1'b0};  // latest low that still waits
        vecs[5] = '{1'b0, 1'b1,  8, 10,  9,  1, 14, 1'b0};  // low one edge too late
        vecs[6] = '{1'b1, 1'b0,  0, -1, 13, 15, 18, 1'b1};  // stuck low, TIMEOUT=4
        vecs[7] = '{1'b1, 1'b1, -1, -1,  9,  1, 14, 1'b0};  // next request after timeout

        sel         = 1'b0;
        reset       = 1'b1;
        req_write   = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        iochrdy_a   = 1'b1;
        iochrdy_b   = 1'b1;
        #1;
        check("reset IOW", int'(IOW_a), 1);
        check("reset IOR", int'(IOR_a), 1);
        check("reset req_ready", int'(req_ready_a), 1);
        check("reset busy", int'(busy_a), 0);
        check("reset rsp_valid", int'(rsp_valid_a), 0);
        check("reset rsp_timeout", int'(rsp_timeout_a), 0);
        check("reset address_load", int'(address_load_a), 0);
        check("reset data_load", int'(data_load_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while IOW is low.
        sel = 1'b0;
        @(negedge clk);
        req_write   = 1'b1;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset IOW_low_before", int'(IOW_a), 0);
        #2;
        reset = 1'b1;
        #1;
        check("midreset IOW", int'(IOW_a), 1);
        check("midreset IOR", int'(IOR_a), 1);
        check("midreset address_load", int'(address_load_a), 0);
        check("midreset data_load", int'(data_load_a), 0);
        check("midreset req_ready", int'(req_ready_a), 1);
        check("midreset busy", int'(busy_a), 0);
        @(negedge clk);
        reset = 1'b0;
        n_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid_a) n_rsp++;
        end
        check("midreset no_rsp", n_rsp, 0);
        wv = vecs[0];
        run_txn(wv, "post_reset_write");

        // Back-to-back: req_valid held high, req_write toggled after acceptance.
        sel = 1'b0;
        n_rsp = 0; first_rsp = -1; second_acc = -1; iow_n = 0; ior_n = 0; both_n = 0;
        @(negedge clk);
        req_write   = 1'b1;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (address_load_a && c > 1 && second_acc < 0) begin
                second_acc  = c;
                req_valid_a = 1'b0;
            end
            if (rsp_valid_a) begin
                n_rsp++;
                if (first_rsp < 0) first_rsp = c;
            end
            if (!IOW_a) iow_n++;
            if (!IOR_a) ior_n++;
            if (!IOW_a && !IOR_a) both_n++;
        end
        req_valid_a = 1'b0;
        check("b2b first_rsp_cycle", first_rsp, 14);
        check("b2b accept_gap", second_acc - first_rsp, 2);
        check("b2b rsp_pulses", n_rsp, 2);
        check("b2b both_low", both_n, 0);
        check("b2b iow_low", iow_n, 9);
        check("b2b ior_low", ior_n, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/isa_cycle_sequencer.md
# isa_cycle_sequencer

Control stage directly upstream of the ISA bus interface datapath on the CT2960 riser. Accepts single I/O read/write requests from the HPS side and generates the `address_load`, `data_load`, `IOW` and `IOR` controls with programmable ISA setup, strobe and hold timing. Honours `IOCHRDY` wait-state extension with a timeout. Reports completion to the HPS with a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_SETUP`, default 2: cycles from address latch to strobe assertion; minimum 1.
- `STROBE_WIDTH`, default 8: minimum strobe-low cycles before `IOCHRDY` is examined; minimum 1.
- `HOLD`, default 2: cycles after strobe release before completion; minimum 1.
- `TIMEOUT`, default 255: maximum `IOCHRDY` wait-state cycles; range 1–255.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  HPS request present.
- `req_write`  in  1  1 = I/O write, 0 = I/O read; sampled with the request.
- `req_ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `req_valid && req_ready`.
- `iochrdy`  in  1  asynchronous ISA channel ready; low requests wait states.
- `address_load`  out  1  latch HPS address into the bus-interface address register.
- `data_load`  out  1  latch the data register: HPS data on writes, bus data on reads.
- `IOW`  out  1  active-low ISA I/O write strobe.
- `IOR`  out  1  active-low ISA I/O read strobe.
- `busy`  out  1  high from acceptance until `rsp_valid` ends.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_timeout`  out  1  qualified by `rsp_valid`; set when the wait-state limit expired. 0 whenever `rsp_valid` = 0.

## Operation
- All outputs are registered.
- Reset values: `IOW` = `IOR` = 1; `address_load`, `data_load`, `busy`, `rsp_valid` and `rsp_timeout` = 0; `req_ready` = 1; state is IDLE.
- `iochrdy` passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value.
- The requester holds address and write data stable from `req_valid` until `rsp_valid`.
- States and transitions:
  - IDLE: on acceptance, latch `req_write` and go to SETUP.
  - SETUP: lasts ADDR_SETUP cycles. `address_load` = 1 in the first SETUP cycle only. On writes, `data_load` = 1 in that same cycle. Strobes stay high.
  - STROBE: lasts STROBE_WIDTH cycles with `IOW` low (write) or `IOR` low (read). In the final cycle, the synchronized `iochrdy` selects the next state: 1 goes to CAPTURE, 0 goes to WAIT.
  - WAIT: the strobe stays low and a wait counter increments each cycle.
    - Synchronized `iochrdy` = 1 goes to CAPTURE.
    - Counter reaching TIMEOUT goes to CAPTURE with the timeout flag set.
    - If both occur in the same cycle, `iochrdy` wins and the flag stays clear.
  - CAPTURE: one cycle, strobe still low. On reads, `data_load` = 1 so the data register captures the bus while `IOR` is low.
  - HOLD: lasts HOLD cycles with both strobes high.
  - DONE: one cycle with `rsp_valid` = 1, `rsp_timeout` = flag, `req_ready` = 0. Then return to IDLE and clear the flag.
- `IOW` and `IOR` are never low simultaneously. Neither strobe is low outside STROBE, WAIT and CAPTURE.
- `req_valid` outside IDLE is ignored. A request asserted during DONE is accepted on the first IDLE cycle.
- `req_write` changes after acceptance have no effect.
- Reset mid-operation: strobes return high and loads drop immediately (asynchronous). No `rsp_valid` is issued and the FSM restarts in IDLE.
- Counters are sized for 8-bit parameters and do not wrap.

## Timing
- Acceptance edge = E0. `address_load` is high during the cycle E0–E1.
- The strobe falls after edge E0+ADDR_SETUP. Strobe-low duration = STROBE_WIDTH + wait cycles + 1.
- No-wait latency from E0 to the `rsp_valid` cycle = ADDR_SETUP + STROBE_WIDTH + 1 + HOLD. With default parameters this is 13 cycles; `rsp_valid` is high during cycle 14.
- Back-to-back throughput: one request per (latency + 2) cycles, counting the IDLE cycle.
- For the synchronized `iochrdy` to be low at the end of STROBE, raw `iochrdy` must be low at least 2 edges before the last STROBE edge.

## Test plan
- Write, defaults, `iochrdy` = 1:
  - `address_load` and `data_load` pulse once, 1 cycle each, in the cycle after E0.
  - `IOW` is low for exactly 9 cycles and `IOR` stays high.
  - `rsp_valid` pulses once, 14 cycles after E0, with `rsp_timeout` = 0.
- Read, defaults:
  - `IOR` is low for 9 cycles.
  - `data_load` is high only in the 9th low cycle, and the datapath register holds the bus value 16'hA55A.
  - `rsp_valid` pulses with `rsp_timeout` = 0.
- Read with `iochrdy` held low from E0+3 until E0+20:
  - `IOR` low period is extended to match.
  - `data_load` occurs in the cycle after the synchronized release.
  - `rsp_timeout` = 0.
- `iochrdy` stuck low, `TIMEOUT` = 4:
  - Strobe low for 8 + 4 + 1 = 13 cycles.
  - `rsp_valid` pulses with `rsp_timeout` = 1.
  - The next request completes with `rsp_timeout` = 0.
- Assert `reset` while `IOW` is low:
  - `IOW` goes high, loads go 0 and `req_ready` goes 1 without waiting for a clock.
  - No `rsp_valid` is issued.
  - A following write completes normally.
- Two back-to-back requests with `req_valid` held high and `req_write` toggled:
  - The second request is accepted exactly 2 cycles after the first `rsp_valid` edge.
  - `IOW` and `IOR` are never low together.
  - Exactly 2 `rsp_valid` pulses are issued.
